// File: rtl/dco_matrix_ctrl_pkg.sv
// Shared types and helpers for the DCO row/column matrix driver.
// State encoding, code-width arithmetic and clamp/saturate helpers.
package dco_matrix_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_RUN  = 2'd2,
    ST_PARK = 2'd3
  } dco_state_e;

  function automatic int code_w_f(
    input int rows,
    input int cols
  );
    return $clog2(rows * cols);
  endfunction

  function automatic int code_max_f(
    input int rows,
    input int cols
  );
    return rows * cols - 1;
  endfunction

  // Symmetric clamp to [-lim, +lim].
  function automatic int clamp_f(
    input int v,
    input int lim
  );
    if (v > lim) begin
      return lim;
    end
    if (v < -lim) begin
      return -lim;
    end
    return v;
  endfunction

  function automatic int sat_f(
    input int v,
    input int hi
  );
    return (v > hi) ? hi : v;
  endfunction

endpackage

// File: rtl/dco_matrix_ctrl_therm_decode.sv
// Combinational code -> active-low row/column thermometer selects.
// Ports: code (integer code), row_sel_b / col_sel_b (active-low).
module dco_therm_decode
  import dco_matrix_ctrl_pkg::*;
#(
  parameter int ROWS   = 17,
  parameter int COLS   = 15,
  parameter int CODE_W = 8
) (
  input  logic [CODE_W-1:0] code,
  output logic [ROWS-2:0]   row_sel_b,
  output logic [COLS-2:0]   col_sel_b
);

  int row_cnt;
  int col_cnt;

  // code = COLS*row_cnt + col_cnt, matching the dco decode.
  always_comb begin
    row_cnt = int'(code) / COLS;
    col_cnt = int'(code) % COLS;
    row_sel_b = '1;
    col_sel_b = '1;
    for (int i = 0; i < ROWS - 1; i++) begin
      row_sel_b[i] = !(i < row_cnt);
    end
    for (int j = 0; j < COLS - 1; j++) begin
      col_sel_b[j] = !(j < col_cnt);
    end
  end

endmodule

// File: rtl/dco_matrix_ctrl.sv
// DCO matrix driver: slew-limited, dithered code into row/col selects.
// Ports: clock/reset, enable, dither_en, code valid/ready/in, selects, status.
module dco_matrix_ctrl
  import dco_matrix_ctrl_pkg::*;
#(
  parameter int NUM_DCO_MATRIX_ROWS    = 17,
  parameter int NUM_DCO_MATRIX_COLUMNS = 15,
  parameter int FRAC_W                 = 4,
  parameter int MAX_STEP               = 8,
  parameter int WAKE_CYCLES            = 16,
  localparam int CODE_W =
    code_w_f(NUM_DCO_MATRIX_ROWS, NUM_DCO_MATRIX_COLUMNS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         dither_en,
  input  logic                         code_valid,
  output logic                         code_ready,
  input  logic [CODE_W+FRAC_W-1:0]     code_in,
  output logic [NUM_DCO_MATRIX_ROWS-2:0]    row_sel_b,
  output logic [NUM_DCO_MATRIX_COLUMNS-2:0] col_sel_b,
  output logic                         sleep_b,
  output logic                         dither,
  output logic [CODE_W-1:0]            code_applied,
  output logic                         saturated,
  output logic                         running
);

  localparam int ROWS     = NUM_DCO_MATRIX_ROWS;
  localparam int COLS     = NUM_DCO_MATRIX_COLUMNS;
  localparam int CODE_MAX = code_max_f(ROWS, COLS);
  localparam int WC_W     = $clog2(WAKE_CYCLES + 1);

  localparam logic [WC_W-1:0] WAKE_LAST =
    WC_W'(WAKE_CYCLES - 1);
  localparam logic [CODE_W-1:0] CODE_MAX_V =
    CODE_W'(CODE_MAX);

  dco_state_e state_q, state_d;

  logic [WC_W-1:0]   wake_q, wake_d;
  logic [CODE_W-1:0] tgt_q, tgt_d, tgt_eff;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              sat_q, sat_d;
  logic [CODE_W-1:0] cur_q, cur_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry;
  logic [CODE_W-1:0] app_q, app_d;
  logic              dith_q;
  logic [CODE_W-1:0] in_int;
  logic              active;
  logic              park_req;
  int                step;

  assign in_int = code_in[CODE_W+FRAC_W-1:FRAC_W];

  // active: normal running; park_req: drive the code to zero.
  assign active   = (state_q == ST_RUN) && enable;
  assign park_req = ((state_q == ST_RUN) && !enable)
                 || (state_q == ST_PARK);

  always_comb begin
    state_d = state_q;
    wake_d  = wake_q;
    unique case (state_q)
      ST_OFF: begin
        wake_d = '0;
        if (enable) begin
          state_d = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (!enable) begin
          state_d = ST_OFF;
        end else if (wake_q == WAKE_LAST) begin
          state_d = ST_RUN;
        end else begin
          wake_d = wake_q + WC_W'(1);
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_PARK;
        end
      end
      ST_PARK: begin
        // Always finish the park; re-wake goes through OFF.
        if (cur_q == '0) begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    tgt_d   = tgt_q;
    frac_d  = frac_q;
    sat_d   = sat_q;
    acc_d   = acc_q;
    carry   = 1'b0;
    tgt_eff = park_req ? '0 : tgt_q;

    // Parking overrides any code accepted in the same cycle.
    if (park_req) begin
      tgt_d  = '0;
      frac_d = '0;
      sat_d  = 1'b0;
    end else if (active && code_valid) begin
      if (int'(in_int) > CODE_MAX) begin
        tgt_d = CODE_MAX_V;
        sat_d = 1'b1;
      end else begin
        tgt_d = in_int;
        sat_d = 1'b0;
      end
      frac_d = code_in[FRAC_W-1:0];
    end

    // First-order delta-sigma; accumulator holds when idle.
    if (active && dither_en) begin
      {carry, acc_d} = {1'b0, acc_q} + {1'b0, frac_q};
    end

    step  = clamp_f(int'(tgt_eff) - int'(cur_q), MAX_STEP);
    cur_d = CODE_W'(int'(cur_q) + step);
    app_d = CODE_W'(sat_f(int'(cur_d) + int'(carry), CODE_MAX));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_OFF;
      wake_q  <= '0;
      tgt_q   <= '0;
      frac_q  <= '0;
      sat_q   <= 1'b0;
      cur_q   <= '0;
      acc_q   <= '0;
      app_q   <= '0;
      dith_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wake_q  <= wake_d;
      tgt_q   <= tgt_d;
      frac_q  <= frac_d;
      sat_q   <= sat_d;
      cur_q   <= cur_d;
      acc_q   <= acc_d;
      app_q   <= app_d;
      dith_q  <= carry;
    end
  end

  dco_therm_decode #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .CODE_W (CODE_W)
  ) u_decode (
    .code      (app_q),
    .row_sel_b (row_sel_b),
    .col_sel_b (col_sel_b)
  );

  assign code_ready   = (state_q == ST_RUN);
  assign running      = (state_q == ST_RUN);
  assign sleep_b      = (state_q != ST_OFF);
  assign dither       = dith_q;
  assign code_applied = app_q;
  assign saturated    = sat_q;

endmodule
